time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 146 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-set entry controller: collects six debounced keypad digits into a BCD
// HHMMSS word, range-checks each digit, and hands the result to the watch counters.
`timescale 1ns/1ps

module time_set_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_time,
  input  logic [9:0]  keypad,
  output logic [23:0] ld_time,
  output logic        load,
  output logic        entry_active,
  output logic [2:0]  digit_pos,
  output logic        key_err,
  output logic        abort
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ENTRY     = 2'd1,
    COMMIT    = 2'd2,
    WAIT_EXIT = 2'd3
  } state_e;

  localparam logic [13:0] TMO_LAST = 14'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [9:0]  kp_q, kp_prev_q;
  logic [23:0] ld_time_q, ld_time_d;
  logic [2:0]  digit_pos_q, digit_pos_d;
  logic [13:0] tmo_q, tmo_d;
  logic        key_err_q, key_err_d;
  logic        abort_q, abort_d;

  logic        press;
  logic        multi_hot;
  logic [3:0]  key_val;
  logic [3:0]  limit;
  logic        valid;
  logic [4:0]  nib_lsb;

  // Press = rising edge of "any key down"; a key already held never re-triggers.
  assign press     = (kp_q != 10'd0) && (kp_prev_q == 10'd0);
  assign multi_hot = !$onehot(kp_q);
  assign nib_lsb   = {3'(3'd5 - digit_pos_q), 2'b00};
  assign valid     = !multi_hot && (key_val <= limit);

  always_comb begin
    key_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (kp_q[i]) key_val = 4'(i);
    end
  end

  // Hours-units limit depends on the tens digit already entered (20..23).
  always_comb begin
    case (digit_pos_q)
      3'd0:    limit = 4'd2;
      3'd1:    limit = (ld_time_q[23:20] == 4'd2) ? 4'd3 : 4'd9;
      3'd2:    limit = 4'd5;
      3'd3:    limit = 4'd9;
      3'd4:    limit = 4'd5;
      default: limit = 4'd9;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      kp_q        <= '0;
      kp_prev_q   <= '0;
      ld_time_q   <= '0;
      digit_pos_q <= '0;
      tmo_q       <= '0;
      key_err_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kp_q        <= keypad;
      kp_prev_q   <= kp_q;
      ld_time_q   <= ld_time_d;
      digit_pos_q <= digit_pos_d;
      tmo_q       <= tmo_d;
      key_err_q   <= key_err_d;
      abort_q     <= abort_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    ld_time_d   = ld_time_q;
    digit_pos_d = digit_pos_q;
    tmo_d       = tmo_q;
    key_err_d   = 1'b0;
    abort_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (set_time) begin
          state_d     = ENTRY;
          ld_time_d   = '0;
          digit_pos_d = '0;
          tmo_d       = '0;
        end
      end
      ENTRY: begin
        if (!set_time) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (press) begin
          tmo_d = '0;
          if (valid) begin
            ld_time_d[nib_lsb +: 4] = key_val;
            if (digit_pos_q == 3'd5) state_d = COMMIT;
            else                     digit_pos_d = 3'(digit_pos_q + 3'd1);
          end else begin
            key_err_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = WAIT_EXIT;
          abort_d = 1'b1;
        end else if (tmo_q != '1) begin
          tmo_d = 14'(tmo_q + 14'd1);
        end
      end
      COMMIT:    state_d = WAIT_EXIT;
      WAIT_EXIT: if (!set_time) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    load         = (state_q == COMMIT);
    entry_active = (state_q == ENTRY);
    ld_time      = ld_time_q;
    digit_pos    = digit_pos_q;
    key_err      = key_err_q;
    abort        = abort_q;
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: nominal entry, digit limits, cancel,
// timeout and mid-entry reset, with hand-computed expectations.
`timescale 1ns/1ps

module tb_time_set_ctrl;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        set_time = 1'b0;
  logic [9:0]  keypad = '0;
  logic [23:0] ld_time;
  logic        load;
  logic        entry_active;
  logic [2:0]  digit_pos;
  logic        key_err;
  logic        abort;

  int vectors  = 0;
  int errors   = 0;
  int load_cnt = 0;

  time_set_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .set_time     (set_time),
    .keypad       (keypad),
    .ld_time      (ld_time),
    .load         (load),
    .entry_active (entry_active),
    .digit_pos    (digit_pos),
    .key_err      (key_err),
    .abort        (abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] key(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction

  // Key goes down; after two edges the press has been acted on.
  task automatic press(input logic [9:0] v);
    keypad = v;
    tick();
    tick();
  endtask

  task automatic release_keys();
    keypad = '0;
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_ld_time", 32'(ld_time), 32'h0);
    check("rst_digit_pos", 32'(digit_pos), 32'd0);
    check("rst_pulses", {29'd0, load, key_err, abort}, 32'd0);
    check("rst_entry", 32'(entry_active), 32'd0);
    rst = 1'b1;
    tick();

    // Nominal entry 23:59:58
    set_time = 1'b1;
    tick();
    check("nom_entry", 32'(entry_active), 32'd1);
    check("nom_pos0", 32'(digit_pos), 32'd0);
    press(key(2));
    check("nom_d0", 32'(ld_time), 32'h200000);
    check("nom_pos1", 32'(digit_pos), 32'd1);
    release_keys();
    press(key(3));
    release_keys();
    press(key(5));
    release_keys();
    press(key(9));
    release_keys();
    press(key(5));
    check("nom_d4", 32'(ld_time), 32'h235950);
    check("nom_pos5", 32'(digit_pos), 32'd5);
    check("nom_no_load_yet", 32'(load), 32'd0);
    release_keys();
    press(key(8));
    check("nom_load", 32'(load), 32'd1);
    check("nom_ld_time", 32'(ld_time), 32'h235958);
    check("nom_commit_pos", 32'(digit_pos), 32'd5);
    check("nom_commit_entry", 32'(entry_active), 32'd0);
    tick();
    check("nom_load_1cyc", 32'(load), 32'd0);
    release_keys();
    press(key(3));
    check("wait_ignore_err", 32'(key_err), 32'd0);
    release_keys();
    check("wait_ignore_ld", 32'(ld_time), 32'h235958);
    check("nom_load_count", 32'(load_cnt), 32'd1);

    // Digit limits and multi-hot
    set_time = 1'b0;
    tick();
    set_time = 1'b1;
    tick();
    check("lim_cleared", 32'(ld_time), 32'h0);
    press(key(2));
    release_keys();
    press(key(4));
    check("lim_24_err", 32'(key_err), 32'd1);
    check("lim_24_pos", 32'(digit_pos), 32'd1);
    check("lim_24_ld", 32'(ld_time), 32'h200000);
    release_keys();
    check("lim_err_1cyc", 32'(key_err), 32'd0);
    press(key(3));
    check("lim_23_ok", 32'(ld_time), 32'h230000);
    check("lim_23_pos", 32'(digit_pos), 32'd2);
    release_keys();
    press(key(6));
    check("lim_m6_err", 32'(key_err), 32'd1);
    check("lim_m6_pos", 32'(digit_pos), 32'd2);
    release_keys();
    press(10'b0000000110);
    check("multi_err", 32'(key_err), 32'd1);
    check("multi_ld", 32'(ld_time), 32'h230000);
    release_keys();
    press(key(1));
    check("cancel_pre", 32'(ld_time), 32'h231000);
    release_keys();

    // Cancel with a press pending in the same cycle
    keypad = key(4);
    tick();
    set_time = 1'b0;
    tick();
    check("cancel_abort", 32'(abort), 32'd1);
    check("cancel_entry", 32'(entry_active), 32'd0);
    check("cancel_ld", 32'(ld_time), 32'h231000);
    check("cancel_excl", {30'd0, load, key_err}, 32'd0);
    tick();
    check("cancel_abort_1cyc", 32'(abort), 32'd0);
    release_keys();
    check("cancel_load_count", 32'(load_cnt), 32'd1);

    // Timeout with a key held across entry
    keypad = key(1);
    tick();
    tick();
    set_time = 1'b1;
    tick();
    check("to_entry", 32'(entry_active), 32'd1);
    repeat (TO - 1) tick();
    check("to_before", {30'd0, entry_active, abort}, 32'b10);
    check("to_held_ignored", 32'(digit_pos), 32'd0);
    tick();
    check("to_abort", 32'(abort), 32'd1);
    check("to_exit", {30'd0, entry_active, load}, 32'd0);
    tick();
    check("to_abort_1cyc", 32'(abort), 32'd0);
    release_keys();
    press(key(5));
    check("to_wait_ignore", {7'd0, ld_time, key_err}, 32'd0);
    check("to_wait_entry", 32'(entry_active), 32'd0);
    release_keys();
    set_time = 1'b0;
    tick();
    set_time = 1'b1;
    tick();
    check("to_reenter", 32'(entry_active), 32'd1);

    // Reset between 5th and 6th digit
    press(key(1));
    release_keys();
    press(key(2));
    release_keys();
    press(key(3));
    release_keys();
    press(key(4));
    release_keys();
    press(key(5));
    release_keys();
    check("rst_mid_pre", 32'(ld_time), 32'h123450);
    keypad = key(6);
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_ld", 32'(ld_time), 32'h0);
    check("rst_mid_pos", 32'(digit_pos), 32'd0);
    check("rst_mid_outs", {28'd0, load, entry_active, key_err, abort}, 32'd0);
    tick();
    keypad = '0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_reentry", 32'(entry_active), 32'd1);
    check("rst_no_load", 32'(load_cnt), 32'd1);
    press(key(9));
    check("rst_pos0_limit", 32'(key_err), 32'd1);
    check("rst_pos0_hold", 32'(digit_pos), 32'd0);
    release_keys();
    set_time = 1'b0;
    tick();
    check("final_abort", 32'(abort), 32'd1);
    check("final_load_count", 32'(load_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
